lab2_proc_mem_arbiter: RTL and testbench

LAB2_PROC_MEM_ARBITER -- requirements
Module: lab2_proc_mem_arbiter

---
 rtl/lab2_proc_mem_arbiter_pkg.sv | 33 +++
 rtl/lab2_proc_mem_arbiter_tag_fifo.sv | 66 ++++++
 rtl/lab2_proc_mem_arbiter.sv | 117 +++++++++++
 tb/tb_lab2_proc_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_proc_mem_arbiter_pkg.sv
// Shared types and constants for the processor/memory request arbiter.
// Memory message layouts, the 1-bit source ID and the round-robin reset value.
package lab2_proc_mem_arbiter_pkg;

    typedef enum logic {
        SRC_IMEM = 1'b0,
        SRC_DMEM = 1'b1
    } src_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // Last-granted value after reset; IMEM here gives dmem the first contested grant.
    localparam src_t RESET_LAST_GRANT = SRC_IMEM;

    function automatic src_t other_src(input src_t s);
        return (s == SRC_IMEM) ? SRC_DMEM : SRC_IMEM;
    endfunction

endpackage

// File: rtl/lab2_proc_mem_arbiter_tag_fifo.sv
// In-order FIFO of source IDs, one per outstanding memory request.
// Push is ignored when full and pop when empty, so there is no full bypass.
module lab2_proc_mem_arbiter_tag_fifo
    import lab2_proc_mem_arbiter_pkg::*;
#(
    parameter int p_num_entries = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  src_t push_src,
    input  logic pop,
    output logic full,
    output logic empty,
    output src_t head
);

    localparam int PtrW = $clog2(p_num_entries);
    localparam int CntW = PtrW + 1;

    src_t            entries_q [p_num_entries];
    src_t            entries_d [p_num_entries];
    logic [PtrW-1:0] head_ptr_q, head_ptr_d;
    logic [PtrW-1:0] tail_ptr_q, tail_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full  = (count_q == CntW'(p_num_entries));
    assign empty = (count_q == '0);
    assign head  = entries_q[head_ptr_q];

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        entries_d  = entries_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        do_push    = push && !full;
        do_pop     = pop && !empty;
        if (do_push) begin
            entries_d[tail_ptr_q] = push_src;
            tail_ptr_d            = tail_ptr_q + 1'b1;
        end
        if (do_pop) begin
            head_ptr_d = head_ptr_q + 1'b1;
        end
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_num_entries; i++) begin
                entries_q[i] <= SRC_IMEM;
            end
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            entries_q  <= entries_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// Round-robin merge of imem/dmem request streams onto one memory port, with
// in-order response routing. Optional grant counters: LAB2_PROC_MEM_ARBITER_STATS_EN.
module lab2_proc_mem_arbiter
    import lab2_proc_mem_arbiter_pkg::*;
#(
    parameter int p_num_entries = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  mem_req_4B_t  imem_reqstream_msg,
    input  logic         imem_reqstream_val,
    output logic         imem_reqstream_rdy,
    input  mem_req_4B_t  dmem_reqstream_msg,
    input  logic         dmem_reqstream_val,
    output logic         dmem_reqstream_rdy,
    output mem_req_4B_t  memreq_msg,
    output logic         memreq_val,
    input  logic         memreq_rdy,
    input  mem_resp_4B_t memresp_msg,
    input  logic         memresp_val,
    output logic         memresp_rdy,
    output mem_resp_4B_t imem_respstream_msg,
    output logic         imem_respstream_val,
    input  logic         imem_respstream_rdy,
    output mem_resp_4B_t dmem_respstream_msg,
    output logic         dmem_respstream_val,
`ifdef LAB2_PROC_MEM_ARBITER_STATS_EN
    output logic [31:0]  num_imem_grants,
    output logic [31:0]  num_dmem_grants,
`endif
    input  logic         dmem_respstream_rdy
);

    src_t last_grant_q, last_grant_d;
    src_t grant;
    src_t head_src;
    logic fifo_full;
    logic fifo_empty;
    logic req_fire;
    logic resp_fire;
    logic route_ok;

    // Request side: everything is gated by reset so outputs stay quiet while it is low.
    always_comb begin
        if (imem_reqstream_val && dmem_reqstream_val) begin
            grant = other_src(last_grant_q);
        end else if (dmem_reqstream_val) begin
            grant = SRC_DMEM;
        end else begin
            grant = SRC_IMEM;
        end
        memreq_val         = reset && (imem_reqstream_val || dmem_reqstream_val) && !fifo_full;
        memreq_msg         = (grant == SRC_DMEM) ? dmem_reqstream_msg : imem_reqstream_msg;
        req_fire           = memreq_val && memreq_rdy;
        imem_reqstream_rdy = req_fire && (grant == SRC_IMEM);
        dmem_reqstream_rdy = req_fire && (grant == SRC_DMEM);
        last_grant_d       = req_fire ? grant : last_grant_q;
    end

    // Response side: routing only looks at registered FIFO state, so a tag pushed
    // this cycle cannot steer a response until the next one.
    always_comb begin
        route_ok            = reset && !fifo_empty;
        imem_respstream_msg = memresp_msg;
        dmem_respstream_msg = memresp_msg;
        imem_respstream_val = route_ok && (head_src == SRC_IMEM) && memresp_val;
        dmem_respstream_val = route_ok && (head_src == SRC_DMEM) && memresp_val;
        memresp_rdy         = route_ok && ((head_src == SRC_IMEM) ? imem_respstream_rdy
                                                                  : dmem_respstream_rdy);
        resp_fire           = memresp_val && memresp_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= RESET_LAST_GRANT;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    lab2_proc_mem_arbiter_tag_fifo #(
        .p_num_entries(p_num_entries)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (req_fire),
        .push_src(grant),
        .pop     (resp_fire),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_src)
    );

`ifdef LAB2_PROC_MEM_ARBITER_STATS_EN
    logic [31:0] num_imem_grants_q, num_imem_grants_d;
    logic [31:0] num_dmem_grants_q, num_dmem_grants_d;

    always_comb begin
        num_imem_grants_d = num_imem_grants_q + 32'(imem_reqstream_rdy);
        num_dmem_grants_d = num_dmem_grants_q + 32'(dmem_reqstream_rdy);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_imem_grants_q <= '0;
            num_dmem_grants_q <= '0;
        end else begin
            num_imem_grants_q <= num_imem_grants_d;
            num_dmem_grants_q <= num_dmem_grants_d;
        end
    end

    assign num_imem_grants = num_imem_grants_q;
    assign num_dmem_grants = num_dmem_grants_q;
`endif

endmodule

// File: tb/tb_lab2_proc_mem_arbiter.sv
// Directed, table-driven bench for lab2_proc_mem_arbiter (depth 4), plus a
// hand-written mid-operation reset sequence.
module tb_lab2_proc_mem_arbiter;
    import lab2_proc_mem_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    mem_req_4B_t  imem_reqstream_msg;
    logic         imem_reqstream_val;
    logic         imem_reqstream_rdy;
    mem_req_4B_t  dmem_reqstream_msg;
    logic         dmem_reqstream_val;
    logic         dmem_reqstream_rdy;
    mem_req_4B_t  memreq_msg;
    logic         memreq_val;
    logic         memreq_rdy;
    mem_resp_4B_t memresp_msg;
    logic         memresp_val;
    logic         memresp_rdy;
    mem_resp_4B_t imem_respstream_msg;
    logic         imem_respstream_val;
    logic         imem_respstream_rdy;
    mem_resp_4B_t dmem_respstream_msg;
    logic         dmem_respstream_val;
    logic         dmem_respstream_rdy;
`ifdef LAB2_PROC_MEM_ARBITER_STATS_EN
    logic [31:0]  num_imem_grants;
    logic [31:0]  num_dmem_grants;
`endif

    lab2_proc_mem_arbiter #(.p_num_entries(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_reqstream_msg (imem_reqstream_msg),
        .imem_reqstream_val (imem_reqstream_val),
        .imem_reqstream_rdy (imem_reqstream_rdy),
        .dmem_reqstream_msg (dmem_reqstream_msg),
        .dmem_reqstream_val (dmem_reqstream_val),
        .dmem_reqstream_rdy (dmem_reqstream_rdy),
        .memreq_msg         (memreq_msg),
        .memreq_val         (memreq_val),
        .memreq_rdy         (memreq_rdy),
        .memresp_msg        (memresp_msg),
        .memresp_val        (memresp_val),
        .memresp_rdy        (memresp_rdy),
        .imem_respstream_msg(imem_respstream_msg),
        .imem_respstream_val(imem_respstream_val),
        .imem_respstream_rdy(imem_respstream_rdy),
        .dmem_respstream_msg(dmem_respstream_msg),
        .dmem_respstream_val(dmem_respstream_val),
`ifdef LAB2_PROC_MEM_ARBITER_STATS_EN
        .num_imem_grants    (num_imem_grants),
        .num_dmem_grants    (num_dmem_grants),
`endif
        .dmem_respstream_rdy(dmem_respstream_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] iv, ia, dv, da, mrdy, rv, rdata, irr, drr;
        logic [31:0] e_mval, e_maddr, e_irdy, e_drdy, e_mresprdy, e_irv, e_drv;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_imem_grants = 0;
    int   exp_dmem_grants = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input logic iv, input logic [31:0] ia, input logic dv,
                               input logic [31:0] da, input logic mrdy, input logic rv,
                               input logic [31:0] rdata, input logic irr, input logic drr);
        imem_reqstream_msg      = '0;
        imem_reqstream_msg.opaque = 8'h11;
        imem_reqstream_msg.addr = ia;
        imem_reqstream_val      = iv;
        dmem_reqstream_msg      = '0;
        dmem_reqstream_msg.opaque = 8'h22;
        dmem_reqstream_msg.addr = da;
        dmem_reqstream_val      = dv;
        memreq_rdy              = mrdy;
        memresp_msg             = '0;
        memresp_msg.data        = rdata;
        memresp_val             = rv;
        imem_respstream_rdy     = irr;
        dmem_respstream_rdy     = drr;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        string p;
        @(negedge clk);
        driveInputs(v.iv[0], v.ia, v.dv[0], v.da, v.mrdy[0], v.rv[0], v.rdata, v.irr[0], v.drr[0]);
        #1;
        p = $sformatf("v%0d", idx);
        checkOutput({p, "_memreq_val"}, 32'(memreq_val), v.e_mval);
        if (v.e_mval[0]) checkOutput({p, "_memreq_addr"}, memreq_msg.addr, v.e_maddr);
        checkOutput({p, "_imem_req_rdy"}, 32'(imem_reqstream_rdy), v.e_irdy);
        checkOutput({p, "_dmem_req_rdy"}, 32'(dmem_reqstream_rdy), v.e_drdy);
        checkOutput({p, "_memresp_rdy"}, 32'(memresp_rdy), v.e_mresprdy);
        checkOutput({p, "_imem_resp_val"}, 32'(imem_respstream_val), v.e_irv);
        checkOutput({p, "_dmem_resp_val"}, 32'(dmem_respstream_val), v.e_drv);
        if (v.e_irv[0]) checkOutput({p, "_imem_resp_data"}, imem_respstream_msg.data, v.rdata);
        if (v.e_drv[0]) checkOutput({p, "_dmem_resp_data"}, dmem_respstream_msg.data, v.rdata);
        if (v.e_mval[0] && v.mrdy[0] && v.e_irdy[0]) exp_imem_grants++;
        if (v.e_mval[0] && v.mrdy[0] && v.e_drdy[0]) exp_dmem_grants++;
    endtask

    initial begin
        // Fields: iv ia dv da mrdy rv rdata irr drr | mval maddr irdy drdy mresprdy irv drv
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 1,                0, 0, 0, 0, 0, 0, 0});
        // Single imem read, then its response.
        vecs.push_back('{1, 'h200, 0, 0, 1, 0, 0, 1, 1,            1, 'h200, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'hdeadbeef, 1, 1,       0, 0, 0, 0, 1, 1, 0});
        // Both valid four cycles: dmem, imem, dmem, imem; FIFO ends full.
        vecs.push_back('{1, 'h300, 1, 'h400, 1, 0, 0, 1, 1,        1, 'h400, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 'h304, 1, 'h404, 1, 0, 0, 1, 1,        1, 'h304, 1, 0, 1, 0, 0});
        vecs.push_back('{1, 'h308, 1, 'h408, 1, 0, 0, 1, 1,        1, 'h408, 0, 1, 1, 0, 0});
        vecs.push_back('{1, 'h30c, 1, 'h40c, 1, 0, 0, 1, 1,        1, 'h30c, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h11, 1, 1,             0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h22, 1, 1,             0, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h33, 1, 1,             0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h44, 1, 1,             0, 0, 0, 0, 1, 1, 0});
        // Stray response with empty FIFO is stalled.
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h55, 1, 1,             0, 0, 0, 0, 0, 0, 0});
        // memreq_rdy low for 3 cycles: pointer holds, dmem wins once rdy rises.
        vecs.push_back('{1, 'h5f0, 1, 'h500, 0, 0, 0, 1, 1,        1, 'h500, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 'h5f0, 1, 'h500, 0, 0, 0, 1, 1,        1, 'h500, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 'h5f0, 1, 'h500, 0, 0, 0, 1, 1,        1, 'h500, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 'h5f0, 1, 'h500, 1, 0, 0, 1, 1,        1, 'h500, 0, 1, 0, 0, 0});
        // Simultaneous push (imem) and pop (dmem head).
        vecs.push_back('{1, 'h600, 0, 0, 1, 1, 'h66, 1, 1,         1, 'h600, 1, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h77, 1, 1,             0, 0, 0, 0, 1, 1, 0});
        // Fill with four dmem requests, then the fifth is blocked even across a pop.
        vecs.push_back('{0, 0, 1, 'h700, 1, 0, 0, 1, 1,            1, 'h700, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 'h704, 1, 0, 0, 1, 1,            1, 'h704, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 'h708, 1, 0, 0, 1, 1,            1, 'h708, 0, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 'h70c, 1, 0, 0, 1, 1,            1, 'h70c, 0, 1, 1, 0, 0});
        vecs.push_back('{1, 'h7f0, 1, 'h710, 1, 0, 0, 1, 1,        0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 'h7f0, 1, 'h710, 1, 1, 'h88, 1, 1,     0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{1, 'h800, 1, 'h900, 1, 0, 0, 1, 1,        1, 'h800, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h91, 1, 1,             0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h92, 1, 1,             0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h93, 1, 1,             0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'h94, 1, 1,             0, 0, 0, 0, 1, 1, 0});
        // dmem head with dmem_respstream_rdy low blocks the imem response behind it.
        vecs.push_back('{0, 0, 1, 'ha00, 1, 0, 0, 1, 1,            1, 'ha00, 0, 1, 0, 0, 0});
        vecs.push_back('{1, 'hb00, 0, 0, 1, 0, 0, 1, 1,            1, 'hb00, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'hcc, 1, 0,             0, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'hcc, 1, 0,             0, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'hcc, 1, 1,             0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 'hdd, 1, 1,             0, 0, 0, 0, 1, 1, 0});

        reset = 1'b0;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset_count", 32'(dut.u_tag_fifo.count_q), 0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
        end

`ifdef LAB2_PROC_MEM_ARBITER_STATS_EN
        @(negedge clk);
        driveInputs(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checkOutput("stats_imem", num_imem_grants, 32'(exp_imem_grants));
        checkOutput("stats_dmem", num_dmem_grants, 32'(exp_dmem_grants));
`endif

        // Two tags in flight, then reset asserts mid-cycle.
        @(negedge clk);
        driveInputs(1, 'hc00, 0, 0, 1, 0, 0, 1, 1);
        #1;
        checkOutput("rst_seq_push_i", 32'(imem_reqstream_rdy), 1);
        @(negedge clk);
        driveInputs(0, 0, 1, 'hd00, 1, 0, 0, 1, 1);
        #1;
        checkOutput("rst_seq_push_d", 32'(dmem_reqstream_rdy), 1);
        @(negedge clk);
        driveInputs(1, 'hc04, 1, 'hd04, 1, 1, 'hee, 1, 1);
        #1;
        checkOutput("rst_seq_count_before", 32'(dut.u_tag_fifo.count_q), 2);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_low_count", 32'(dut.u_tag_fifo.count_q), 0);
        checkOutput("rst_low_memreq_val", 32'(memreq_val), 0);
        checkOutput("rst_low_imem_rdy", 32'(imem_reqstream_rdy), 0);
        checkOutput("rst_low_dmem_rdy", 32'(dmem_reqstream_rdy), 0);
        checkOutput("rst_low_memresp_rdy", 32'(memresp_rdy), 0);
        checkOutput("rst_low_imem_resp_val", 32'(imem_respstream_val), 0);
        checkOutput("rst_low_dmem_resp_val", 32'(dmem_respstream_val), 0);
`ifdef LAB2_PROC_MEM_ARBITER_STATS_EN
        checkOutput("rst_low_stats_imem", num_imem_grants, 0);
        checkOutput("rst_low_stats_dmem", num_dmem_grants, 0);
`endif
        @(negedge clk);
        checkOutput("rst_low_memreq_val_2", 32'(memreq_val), 0);
        reset = 1'b1;
        driveInputs(0, 0, 0, 0, 1, 1, 'hef, 1, 1);
        #1;
        checkOutput("post_rst_stray_memresp_rdy", 32'(memresp_rdy), 0);
        checkOutput("post_rst_stray_imem_val", 32'(imem_respstream_val), 0);
        checkOutput("post_rst_stray_dmem_val", 32'(dmem_respstream_val), 0);
        @(negedge clk);
        driveInputs(1, 'he00, 1, 'hf00, 1, 0, 0, 1, 1);
        #1;
        checkOutput("post_rst_count", 32'(dut.u_tag_fifo.count_q), 0);
        checkOutput("post_rst_dmem_first", 32'(dmem_reqstream_rdy), 1);
        checkOutput("post_rst_addr", memreq_msg.addr, 'hf00);
        @(negedge clk);
        driveInputs(0, 0, 0, 0, 0, 0, 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
